// File: rtl/cpr_therapy_sequencer.sv
// CPR compression/ventilation pacer (30:2 pattern) plus drug-pump req/ack sequencer with post-dose lockout.
// Optional rhythm-check pause enabled by defining CPR_RHYTHM_CHECK_EN.
module cpr_therapy_sequencer #(
    parameter int COMPRESS_PERIOD        = 50,
    parameter int COMPRESSIONS_PER_CYCLE = 30,
    parameter int BREATHS_PER_CYCLE      = 2,
    parameter int BREATH_PERIOD          = 100,
    parameter int LOCKOUT_CYCLES         = 1000,
    parameter int CHECK_INTERVAL         = 5,
    parameter int CHECK_CYCLES           = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpr_activate,
    input  logic       drug_delivery_activate,
    input  logic [3:0] drug_dosage,
    input  logic       inject_ack,
    output logic       compress_pulse,
    output logic       ventilate_pulse,
    output logic       inject_req,
    output logic [3:0] dose_out,
    output logic [1:0] cpr_state,
    output logic [7:0] cycle_count,
    output logic [7:0] dose_count,
    output logic       lockout_active,
    output logic       check_window
);

    localparam int PERIOD_MAX = (COMPRESS_PERIOD > BREATH_PERIOD) ? COMPRESS_PERIOD : BREATH_PERIOD;
`ifdef CPR_RHYTHM_CHECK_EN
    localparam int TIMER_MAX  = (CHECK_CYCLES > PERIOD_MAX) ? CHECK_CYCLES : PERIOD_MAX;
    localparam int CW         = (CHECK_INTERVAL > 1) ? $clog2(CHECK_INTERVAL) : 1;
`else
    localparam int TIMER_MAX  = PERIOD_MAX;
`endif
    localparam int TW         = $clog2(TIMER_MAX);
    localparam int PULSE_MAX  = (COMPRESSIONS_PER_CYCLE > BREATHS_PER_CYCLE) ?
                                COMPRESSIONS_PER_CYCLE : BREATHS_PER_CYCLE;
    localparam int PW         = $clog2(PULSE_MAX + 1);
    localparam int LW         = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    localparam logic [TW-1:0] COMPRESS_RELOAD = TW'(COMPRESS_PERIOD - 1);
    localparam logic [TW-1:0] BREATH_RELOAD   = TW'(BREATH_PERIOD - 1);
    localparam logic [PW-1:0] N_COMPRESS      = PW'(COMPRESSIONS_PER_CYCLE);
    localparam logic [PW-1:0] N_BREATHS       = PW'(BREATHS_PER_CYCLE);
    localparam logic [LW-1:0] LOCK_RELOAD     = LW'(LOCKOUT_CYCLES - 1);

    if (COMPRESS_PERIOD < 2 || BREATH_PERIOD < 2 || COMPRESSIONS_PER_CYCLE < 1 ||
        BREATHS_PER_CYCLE < 1 || LOCKOUT_CYCLES < 1 || CHECK_INTERVAL < 1 ||
        CHECK_CYCLES < 1) begin : g_param_check
        $error("cpr_therapy_sequencer: parameter out of range");
    end

    typedef enum logic [1:0] {
        CPR_IDLE      = 2'b00,
        CPR_COMPRESS  = 2'b01,
        CPR_VENTILATE = 2'b10,
        CPR_CHECK     = 2'b11
    } cpr_state_e;

    typedef enum logic [1:0] {
        D_IDLE = 2'b00,
        D_REQ  = 2'b01,
        D_LOCK = 2'b10
    } drug_state_e;

    cpr_state_e    cpr_q, cpr_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [7:0]    cycle_cnt_q, cycle_cnt_d;
    logic          compress_q, compress_d;
    logic          ventilate_q, ventilate_d;
`ifdef CPR_RHYTHM_CHECK_EN
    logic [CW-1:0] chk_cnt_q, chk_cnt_d;
    logic          check_window_q, check_window_d;
`endif

    drug_state_e   drug_q, drug_d;
    logic [3:0]    dose_q, dose_d;
    logic          inject_req_q, inject_req_d;
    logic [7:0]    dose_cnt_q, dose_cnt_d;
    logic [LW-1:0] lock_timer_q, lock_timer_d;
    logic          lockout_q, lockout_d;

    // ---------------- CPR pacing FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpr_q          <= CPR_IDLE;
            timer_q        <= '0;
            pulse_cnt_q    <= '0;
            cycle_cnt_q    <= '0;
            compress_q     <= 1'b0;
            ventilate_q    <= 1'b0;
`ifdef CPR_RHYTHM_CHECK_EN
            chk_cnt_q      <= '0;
            check_window_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values, so ordering here is irrelevant.
            cpr_q          <= cpr_d;
            timer_q        <= timer_d;
            pulse_cnt_q    <= pulse_cnt_d;
            cycle_cnt_q    <= cycle_cnt_d;
            compress_q     <= compress_d;
            ventilate_q    <= ventilate_d;
`ifdef CPR_RHYTHM_CHECK_EN
            chk_cnt_q      <= chk_cnt_d;
            check_window_q <= check_window_d;
`endif
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a value unassigned (no latches).
        cpr_d       = cpr_q;
        timer_d     = timer_q;
        pulse_cnt_d = pulse_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        compress_d  = 1'b0;
        ventilate_d = 1'b0;
`ifdef CPR_RHYTHM_CHECK_EN
        chk_cnt_d      = chk_cnt_q;
        check_window_d = 1'b0;
`endif
        unique case (cpr_q)
            CPR_IDLE: begin
                if (cpr_activate) begin
                    cpr_d       = CPR_COMPRESS;
                    timer_d     = '0;
                    pulse_cnt_d = '0;
                end
            end
            CPR_COMPRESS: begin
                if (!cpr_activate) begin
                    cpr_d       = CPR_IDLE;
                    timer_d     = '0;
                    pulse_cnt_d = '0;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else if (pulse_cnt_q < N_COMPRESS) begin
                    compress_d  = 1'b1;
                    pulse_cnt_d = pulse_cnt_q + PW'(1);
                    timer_d     = COMPRESS_RELOAD;
                end else begin
                    // Ventilation opens with its first breath on the entry edge.
                    cpr_d       = CPR_VENTILATE;
                    ventilate_d = 1'b1;
                    pulse_cnt_d = PW'(1);
                    timer_d     = BREATH_RELOAD;
                end
            end
            CPR_VENTILATE: begin
                if (!cpr_activate) begin
                    cpr_d       = CPR_IDLE;
                    timer_d     = '0;
                    pulse_cnt_d = '0;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else if (pulse_cnt_q < N_BREATHS) begin
                    ventilate_d = 1'b1;
                    pulse_cnt_d = pulse_cnt_q + PW'(1);
                    timer_d     = BREATH_RELOAD;
                end else begin
                    if (cycle_cnt_q != 8'hFF) cycle_cnt_d = cycle_cnt_q + 8'd1;
                    // Next cycle starts immediately with its first compression.
                    cpr_d       = CPR_COMPRESS;
                    compress_d  = 1'b1;
                    pulse_cnt_d = PW'(1);
                    timer_d     = COMPRESS_RELOAD;
`ifdef CPR_RHYTHM_CHECK_EN
                    if (chk_cnt_q == CW'(CHECK_INTERVAL - 1)) begin
                        chk_cnt_d      = '0;
                        cpr_d          = CPR_CHECK;
                        compress_d     = 1'b0;
                        pulse_cnt_d    = '0;
                        check_window_d = 1'b1;
                        timer_d        = TW'(CHECK_CYCLES - 1);
                    end else begin
                        chk_cnt_d = chk_cnt_q + CW'(1);
                    end
`endif
                end
            end
            CPR_CHECK: begin
`ifdef CPR_RHYTHM_CHECK_EN
                if (timer_q != '0) begin
                    timer_d        = timer_q - TW'(1);
                    check_window_d = 1'b1;
                end else if (cpr_activate) begin
                    cpr_d       = CPR_COMPRESS;
                    compress_d  = 1'b1;
                    pulse_cnt_d = PW'(1);
                    timer_d     = COMPRESS_RELOAD;
                end else begin
                    cpr_d       = CPR_IDLE;
                    pulse_cnt_d = '0;
                end
`else
                cpr_d = CPR_IDLE;
`endif
            end
        endcase
    end

    // ---------------- Drug pump handshake FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drug_q       <= D_IDLE;
            dose_q       <= '0;
            inject_req_q <= 1'b0;
            dose_cnt_q   <= '0;
            lock_timer_q <= '0;
            lockout_q    <= 1'b0;
        end else begin
            drug_q       <= drug_d;
            dose_q       <= dose_d;
            inject_req_q <= inject_req_d;
            dose_cnt_q   <= dose_cnt_d;
            lock_timer_q <= lock_timer_d;
            lockout_q    <= lockout_d;
        end
    end

    always_comb begin
        drug_d       = drug_q;
        dose_d       = dose_q;
        inject_req_d = 1'b0;
        dose_cnt_d   = dose_cnt_q;
        lock_timer_d = lock_timer_q;
        lockout_d    = 1'b0;
        case (drug_q)
            D_IDLE: begin
                if (drug_delivery_activate && drug_dosage != 4'd0) begin
                    drug_d       = D_REQ;
                    inject_req_d = 1'b1;
                    dose_d       = drug_dosage;
                end
            end
            D_REQ: begin
                // A pending request is only retired by the pump's acknowledge.
                if (inject_ack) begin
                    drug_d       = D_LOCK;
                    dose_d       = '0;
                    lockout_d    = 1'b1;
                    lock_timer_d = LOCK_RELOAD;
                    if (dose_cnt_q != 8'hFF) dose_cnt_d = dose_cnt_q + 8'd1;
                end else begin
                    inject_req_d = 1'b1;
                end
            end
            D_LOCK: begin
                if (lock_timer_q != '0) begin
                    lock_timer_d = lock_timer_q - LW'(1);
                    lockout_d    = 1'b1;
                end else begin
                    drug_d = D_IDLE;
                end
            end
            default: drug_d = D_IDLE;
        endcase
    end

    assign compress_pulse  = compress_q;
    assign ventilate_pulse = ventilate_q;
    assign cpr_state       = cpr_q;
    assign cycle_count     = cycle_cnt_q;
    assign inject_req      = inject_req_q;
    assign dose_out        = dose_q;
    assign dose_count      = dose_cnt_q;
    assign lockout_active  = lockout_q;
`ifdef CPR_RHYTHM_CHECK_EN
    assign check_window    = check_window_q;
`else
    assign check_window    = 1'b0;
`endif

endmodule

// File: tb/tb_cpr_therapy_sequencer.sv
// Scoreboard bench for cpr_therapy_sequencer: stimulus queues expected pulse/request events,
// a monitor pops and compares them as the DUT produces them.
module tb_cpr_therapy_sequencer;

    localparam int CP = 4, NC = 3, NB = 2, BP = 6, LK = 10, CI = 2, CC = 5;
    localparam int EV_COMP = 0, EV_VENT = 1, EV_REQ = 2, EV_REQ_END = 3, EV_LOCK_END = 4;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cpr_activate = 1'b0;
    logic       drug_delivery_activate = 1'b0;
    logic [3:0] drug_dosage = 4'd0;
    logic       inject_ack = 1'b0;
    logic       compress_pulse, ventilate_pulse, inject_req, lockout_active, check_window;
    logic [3:0] dose_out;
    logic [1:0] cpr_state;
    logic [7:0] cycle_count, dose_count;

    ev_t cpr_q[$];
    ev_t drug_q[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_pass = 0;
    int  t0, a;

    cpr_therapy_sequencer #(
        .COMPRESS_PERIOD(CP), .COMPRESSIONS_PER_CYCLE(NC), .BREATHS_PER_CYCLE(NB),
        .BREATH_PERIOD(BP), .LOCKOUT_CYCLES(LK), .CHECK_INTERVAL(CI), .CHECK_CYCLES(CC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cpr_activate(cpr_activate),
        .drug_delivery_activate(drug_delivery_activate), .drug_dosage(drug_dosage),
        .inject_ack(inject_ack), .compress_pulse(compress_pulse),
        .ventilate_pulse(ventilate_pulse), .inject_req(inject_req), .dose_out(dose_out),
        .cpr_state(cpr_state), .cycle_count(cycle_count), .dose_count(dose_count),
        .lockout_active(lockout_active), .check_window(check_window)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_cpr(input int kind, input int c);
        ev_t e;
        e.kind = kind; e.cyc = c; e.val = 0;
        cpr_q.push_back(e);
    endtask

    task automatic push_drug(input int kind, input int c, input int v);
        ev_t e;
        e.kind = kind; e.cyc = c; e.val = v;
        drug_q.push_back(e);
    endtask

    task automatic pop_cpr(input int kind);
        ev_t e;
        if (cpr_q.size() == 0) begin
            check("cpr_unexpected_pulse_kind", kind, 32'hFFFF_FFFF);
        end else begin
            e = cpr_q.pop_front();
            check("cpr_pulse_kind", kind, e.kind);
            check("cpr_pulse_cycle", cyc, e.cyc);
        end
    endtask

    task automatic pop_drug(input int kind, input int v);
        ev_t e;
        if (drug_q.size() == 0) begin
            check("drug_unexpected_event_kind", kind, 32'hFFFF_FFFF);
        end else begin
            e = drug_q.pop_front();
            check("drug_event_kind", kind, e.kind);
            check("drug_event_cycle", cyc, e.cyc);
            check("drug_event_value", v, e.val);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        logic prev_req, prev_lock;
        int   req_len, lock_len;
        logic [3:0] req_dose;
        prev_req = 1'b0; prev_lock = 1'b0; req_len = 0; lock_len = 0; req_dose = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req = 1'b0; prev_lock = 1'b0; req_len = 0; lock_len = 0;
            end else begin
                if (compress_pulse || ventilate_pulse)
                    check("pulse_exclusive", 32'(compress_pulse & ventilate_pulse), 0);
                if (compress_pulse)  pop_cpr(EV_COMP);
                if (ventilate_pulse) pop_cpr(EV_VENT);
                if (inject_req && !prev_req) begin
                    req_dose = dose_out;
                    req_len  = 0;
                    pop_drug(EV_REQ, 32'(dose_out));
                end
                if (inject_req) begin
                    req_len++;
                    check("dose_out_stable", dose_out, req_dose);
                end
                if (!inject_req && prev_req) pop_drug(EV_REQ_END, req_len);
                if (lockout_active && !prev_lock) lock_len = 0;
                if (lockout_active) lock_len++;
                if (!lockout_active && prev_lock) pop_drug(EV_LOCK_END, lock_len);
                prev_req  = inject_req;
                prev_lock = lockout_active;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("reset_all_outputs",
              {compress_pulse, ventilate_pulse, inject_req, dose_out, cpr_state,
               cycle_count, dose_count, lockout_active, check_window}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full 30:2-style cycle with cpr_activate held, then drop between compressions
        t0 = cyc + 1;
        cpr_activate = 1'b1;
        push_cpr(EV_COMP, t0 + 1);  push_cpr(EV_COMP, t0 + 5);  push_cpr(EV_COMP, t0 + 9);
        push_cpr(EV_VENT, t0 + 13); push_cpr(EV_VENT, t0 + 19);
        push_cpr(EV_COMP, t0 + 25); push_cpr(EV_COMP, t0 + 29);
        wait_until(t0 + 1);
        check("cpr_state_compress", cpr_state, 2'b01);
        wait_until(t0 + 13);
        check("cpr_state_ventilate", cpr_state, 2'b10);
        check("cycle_count_mid", cycle_count, 0);
        wait_until(t0 + 25);
        check("cycle_count_after_cycle", cycle_count, 1);
        check("cpr_state_recompress", cpr_state, 2'b01);
        check("check_window_off", check_window, 0);
        wait_until(t0 + 30);
        cpr_activate = 1'b0;
        wait_until(t0 + 31);
        check("cpr_state_abort_idle", cpr_state, 2'b00);
        check("cycle_count_retained", cycle_count, 1);
        wait_until(t0 + 45);

        // Dose 3, deactivated and dosage changed while pending, ack after 5 cycles
        a = cyc + 1;
        drug_delivery_activate = 1'b1;
        drug_dosage = 4'd3;
        push_drug(EV_REQ, a, 3);
        push_drug(EV_REQ_END, a + 5, 5);
        push_drug(EV_LOCK_END, a + 15, LK);
        wait_until(a);
        drug_delivery_activate = 1'b0;
        drug_dosage = 4'd7;
        wait_until(a + 3);
        check("dose_out_held", dose_out, 3);
        wait_until(a + 4);
        inject_ack = 1'b1;
        wait_until(a + 5);
        inject_ack = 1'b0;
        check("dose_count_one", dose_count, 1);
        check("lockout_started", lockout_active, 1);
        check("dose_out_cleared", dose_out, 0);
        wait_until(a + 7);
        inject_ack = 1'b1;
        wait_until(a + 8);
        inject_ack = 1'b0;
        wait_until(a + 20);
        check("dose_count_ack_in_lock_ignored", dose_count, 1);

        // Activation held through lockout: exactly one new request after DIDLE
        a = cyc + 1;
        drug_delivery_activate = 1'b1;
        drug_dosage = 4'd5;
        push_drug(EV_REQ, a, 5);
        push_drug(EV_REQ_END, a + 2, 2);
        push_drug(EV_LOCK_END, a + 12, LK);
        push_drug(EV_REQ, a + 13, 5);
        push_drug(EV_REQ_END, a + 14, 1);
        push_drug(EV_LOCK_END, a + 24, LK);
        wait_until(a + 1);
        inject_ack = 1'b1;
        wait_until(a + 2);
        inject_ack = 1'b0;
        wait_until(a + 12);
        check("no_req_at_lock_end", inject_req, 0);
        wait_until(a + 13);
        check("req_after_lockout", inject_req, 1);
        inject_ack = 1'b1;
        wait_until(a + 14);
        inject_ack = 1'b0;
        wait_until(a + 20);
        drug_delivery_activate = 1'b0;
        wait_until(a + 30);
        check("dose_count_three", dose_count, 3);

        // Zero dosage is ignored
        drug_delivery_activate = 1'b1;
        drug_dosage = 4'd0;
        repeat (10) @(negedge clk);
        check("zero_dose_no_req", inject_req, 0);
        drug_delivery_activate = 1'b0;
        @(negedge clk);

        // Asynchronous reset mid-DREQ and mid-COMPRESS
        t0 = cyc + 1;
        cpr_activate = 1'b1;
        drug_delivery_activate = 1'b1;
        drug_dosage = 4'd2;
        push_cpr(EV_COMP, t0 + 1);
        push_cpr(EV_COMP, t0 + 5);
        push_drug(EV_REQ, t0, 2);
        wait_until(t0 + 6);
        check("pre_reset_req", inject_req, 1);
        #2;
        rst_n = 1'b0;
        cpr_activate = 1'b0;
        drug_delivery_activate = 1'b0;
        drug_dosage = 4'd0;
        #1;
        check("async_reset_req", inject_req, 0);
        check("async_reset_state", cpr_state, 0);
        check("async_reset_counts", {cycle_count, dose_count}, 0);
        check("async_reset_all_outputs",
              {compress_pulse, ventilate_pulse, inject_req, dose_out, cpr_state,
               cycle_count, dose_count, lockout_active, check_window}, 0);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

`ifdef CPR_RHYTHM_CHECK_EN
        // Two full cycles, then a rhythm-check pause, then compressions resume
        t0 = cyc + 1;
        cpr_activate = 1'b1;
        push_cpr(EV_COMP, t0 + 1);  push_cpr(EV_COMP, t0 + 5);  push_cpr(EV_COMP, t0 + 9);
        push_cpr(EV_VENT, t0 + 13); push_cpr(EV_VENT, t0 + 19);
        push_cpr(EV_COMP, t0 + 25); push_cpr(EV_COMP, t0 + 29); push_cpr(EV_COMP, t0 + 33);
        push_cpr(EV_VENT, t0 + 37); push_cpr(EV_VENT, t0 + 43);
        push_cpr(EV_COMP, t0 + 54); push_cpr(EV_COMP, t0 + 58);
        wait_until(t0 + 49);
        check("check_state", cpr_state, 2'b11);
        check("check_window_start", check_window, 1);
        check("cycle_count_two", cycle_count, 2);
        wait_until(t0 + 53);
        check("check_window_end", check_window, 1);
        wait_until(t0 + 54);
        check("check_window_closed", check_window, 0);
        check("check_resume_compress", cpr_state, 2'b01);
        wait_until(t0 + 59);
        cpr_activate = 1'b0;
        wait_until(t0 + 70);
`endif

        check("cpr_events_outstanding", cpr_q.size(), 0);
        check("drug_events_outstanding", drug_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpr_therapy_sequencer.md
Name: cpr_therapy_sequencer

Overview:
- Sequences the CPR compression actuator and the drug-injection pump from the per-cycle activation and dosage decisions of the heart monitor.
- Generates paced compression and ventilation strokes in a 30:2 pattern while CPR is requested.
- Runs an independent req/ack handshake to the drug pump, with a post-dose lockout timer.
- Sits between the monitor decision logic and the actuator/pump drivers.

Parameters:
- COMPRESS_PERIOD, 50, clock cycles between compression pulses (>=2)
- COMPRESSIONS_PER_CYCLE, 30, compressions before ventilation (>=1)
- BREATHS_PER_CYCLE, 2, ventilation pulses per cycle (>=1)
- BREATH_PERIOD, 100, clock cycles between ventilation pulses (>=2)
- LOCKOUT_CYCLES, 1000, minimum cycles after a dose acknowledge before the next request (>=1)
- CHECK_INTERVAL, 5, completed 30:2 cycles between rhythm checks (option only)
- CHECK_CYCLES, 200, length of the rhythm-check pause (option only)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpr_activate  in  1  level: CPR requested
- drug_delivery_activate  in  1  level: drug delivery requested
- drug_dosage  in  4  requested dose level; 0 means no dose
- inject_ack  in  1  pump accepted the dose
- compress_pulse  out  1  one-cycle compression stroke
- ventilate_pulse  out  1  one-cycle ventilation stroke
- inject_req  out  1  dose request to the pump
- dose_out  out  4  latched dose; valid while inject_req=1
- cpr_state  out  2  00 IDLE, 01 COMPRESS, 10 VENTILATE, 11 CHECK
- cycle_count  out  8  completed 30:2 cycles; saturates at 255
- dose_count  out  8  acknowledged doses; saturates at 255
- lockout_active  out  1  drug lockout timer running
- check_window  out  1  rhythm-check pause active

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0, both FSMs idle, all counters 0.
- All outputs are registered.
- CPR FSM:
  - IDLE->COMPRESS when cpr_activate=1 is sampled.
  - The first compress_pulse fires on the first cycle in COMPRESS. Subsequent pulses follow every COMPRESS_PERIOD cycles.
  - After the COMPRESSIONS_PER_CYCLE-th pulse, wait COMPRESS_PERIOD cycles, then go to VENTILATE.
  - VENTILATE: the first ventilate_pulse fires on entry, then every BREATH_PERIOD cycles. After the BREATHS_PER_CYCLE-th pulse, wait BREATH_PERIOD cycles.
  - At the end of VENTILATE, cycle_count increments (saturating). Next state is COMPRESS if cpr_activate=1, else IDLE.
  - cpr_activate=0 sampled in COMPRESS or VENTILATE: go to IDLE next cycle; pulse and period counters clear; no pulse in that cycle; cycle_count is retained.
  - compress_pulse and ventilate_pulse are never high together.
  - cycle_count clears only on reset.
- Drug FSM (DIDLE, DREQ, DLOCK), independent of the CPR FSM:
  - DIDLE->DREQ when drug_delivery_activate=1, drug_dosage!=0, and lockout is not running. drug_dosage is latched into dose_out on that edge.
  - Activation with drug_dosage=0 is ignored.
  - DREQ: inject_req=1 and dose_out is held stable until inject_ack=1 is sampled. Input changes, including deactivation, do not withdraw a pending request.
  - On ack: inject_req drops next cycle, dose_count increments (saturating), go to DLOCK.
  - DLOCK: lockout_active=1 for exactly LOCKOUT_CYCLES cycles, then DIDLE. dose_out returns to 0 on leaving DREQ.
  - inject_ack while in DIDLE or DLOCK is ignored.
- A compression pulse and a drug request in the same cycle are both allowed.
- Counter widths are sized by $clog2 of the relevant parameter.

Optional Feature:
- Macro: CPR_RHYTHM_CHECK_EN.
- Defined:
  - When cycle_count (pre-saturation internal counter) reaches a multiple of CHECK_INTERVAL at the end of VENTILATE, enter CHECK instead of COMPRESS.
  - CHECK: check_window=1 for CHECK_CYCLES cycles with no pulses. Then go to COMPRESS if cpr_activate=1, else IDLE.
  - cpr_activate=0 during CHECK has no effect until the check window ends.
- Undefined: CHECK state is unreachable; check_window is tied to 0.

Test Plan (COMPRESS_PERIOD=4, COMPRESSIONS_PER_CYCLE=3, BREATHS_PER_CYCLE=2, BREATH_PERIOD=6, LOCKOUT_CYCLES=10, CHECK_INTERVAL=2, CHECK_CYCLES=5):
- Hold cpr_activate=1 from cycle 0 -> compress_pulse at cycles 1,5,9; ventilate_pulse at 13,19; cycle_count=1 at cycle 25; compress_pulse again at 25.
- Drop cpr_activate between the 2nd and 3rd compression -> cpr_state=IDLE next cycle; no further pulses; cycle_count unchanged.
- drug_delivery_activate=1, drug_dosage=3, ack delayed 5 cycles -> inject_req high 5 cycles with dose_out=3; then lockout_active high 10 cycles; dose_count=1.
- drug_delivery_activate held high through lockout -> exactly one new request, issued the cycle after lockout ends.
- drug_dosage=0 with activate=1 -> inject_req stays 0.
- Assert rst_n=0 mid-DREQ and mid-COMPRESS -> all outputs 0 immediately.
- With CPR_RHYTHM_CHECK_EN, 2 full cycles -> check_window high 5 cycles with no pulses, then compressions resume.
